// File: rtl/mul4_fitness_sequencer.sv
// mul4_fitness_sequencer: drives LFSR operand vectors into a candidate mul4 datapath and scores its bitwise accuracy
module mul4_fitness_sequencer #(
   parameter int          N_VECTORS     = 256,
   parameter int          SETTLE_CYCLES = 1,
   parameter logic [63:0] SEED          = 64'hACE1_1234_5EED_0001
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 start,
   input  logic                                 seed_load,
   input  logic [63:0]                          seed_in,
   output logic [15:0]                          a1,
   output logic [15:0]                          a0,
   output logic [15:0]                          b1,
   output logic [15:0]                          b0,
   input  logic [15:0]                          y3,
   input  logic [15:0]                          y2,
   input  logic [15:0]                          y1,
   input  logic [15:0]                          y0,
   output logic                                 busy,
   output logic                                 done,
   output logic [$clog2(N_VECTORS*64+1)-1:0]    score,
   output logic [$clog2(N_VECTORS+1)-1:0]       exact_hits
);
   localparam int SCORE_W = $clog2(N_VECTORS*64+1);
   localparam int HITS_W  = $clog2(N_VECTORS+1);
   localparam int SET_W   = $clog2(SETTLE_CYCLES+1);
   // Galois feedback mask for taps 64,63,61,60 (bits 63,62,60,59)
   localparam logic [63:0] TAPS = 64'hD800_0000_0000_0000;
   typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
   state_t            state;
   logic [63:0]       lfsr;
   logic [63:0]       lfsr_next;
   logic [63:0]       gold;
   logic [63:0]       err;
   logic [6:0]        match;
   logic [HITS_W-1:0] vec_cnt;
   logic [SET_W-1:0]  settle_cnt;
   // next LFSR value and per-vector bit agreement with the golden product
   always_comb begin
      lfsr_next = {1'b0, lfsr[63:1]} ^ (lfsr[0] ? TAPS : 64'd0);
      err       = {y3, y2, y1, y0} ^ gold;
      match     = 7'(64 - $countones(err));
   end
   // run sequencer: seeding, operand drive, settle timing and scoring
   always_ff @(posedge clk) begin
      if (rst) begin
         state                <= IDLE;
         busy                 <= 1'b0;
         done                 <= 1'b0;
         score                <= '0;
         exact_hits           <= '0;
         {a1, a0, b1, b0}     <= '0;
         lfsr                 <= SEED;
         gold                 <= '0;
         vec_cnt              <= '0;
         settle_cnt           <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (seed_load)
                  lfsr <= (seed_in == 64'd0) ? SEED : seed_in;
               else if (start) begin
                  score            <= '0;
                  exact_hits       <= '0;
                  vec_cnt          <= '0;
                  settle_cnt       <= '0;
                  {a1, a0, b1, b0} <= lfsr;
                  busy             <= 1'b1;
                  state            <= DRIVE;
               end
            end
            DRIVE: begin
               gold       <= 64'({a1, a0}) * 64'({b1, b0});
               settle_cnt <= settle_cnt + SET_W'(1);
               if (settle_cnt == SET_W'(SETTLE_CYCLES - 1)) begin
                  settle_cnt <= '0;
                  state      <= SAMPLE;
               end
            end
            SAMPLE: begin
               score      <= score + SCORE_W'(match);
               exact_hits <= exact_hits + HITS_W'(err == 64'd0);
               lfsr       <= lfsr_next;
               vec_cnt    <= vec_cnt + HITS_W'(1);
               if (vec_cnt == HITS_W'(N_VECTORS - 1)) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  {a1, a0, b1, b0} <= lfsr_next;
                  state            <= DRIVE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mul4_fitness_sequencer.sv
// tb_mul4_fitness_sequencer: vector-level model of operand stream and score, checked every cycle
module tb_mul4_fitness_sequencer;
   localparam logic [63:0] SEED = 64'hACE1_1234_5EED_0001;
   localparam int MN = 256;
   localparam int MLAST = MN * 2;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // main instance, N=256
   logic        m_start_sig = 0, m_seed_load = 0;
   logic [63:0] m_seed_in = '0;
   logic [15:0] m_a1, m_a0, m_b1, m_b0;
   logic [63:0] m_ops, m_y;
   logic        m_busy, m_done;
   logic [14:0] m_score;
   logic [8:0]  m_hits;
   int          m_mode = 0;
   // short-run instance, N=4
   logic        f_start = 0, f_seed_load = 0;
   logic [63:0] f_seed_in = '0;
   logic [15:0] f_a1, f_a0, f_b1, f_b0;
   logic [63:0] f_ops, f_y;
   logic        f_busy, f_done;
   logic [8:0]  f_score;
   logic [2:0]  f_hits;
   // single-vector instance, N=1, candidate output tied to zero
   logic        o_start = 0, o_seed_load = 0;
   logic [63:0] o_seed_in = '0;
   logic [15:0] o_a1, o_a0, o_b1, o_b0;
   logic [63:0] o_ops, o_y;
   logic        o_busy, o_done;
   logic [6:0]  o_score;
   logic [0:0]  o_hits;

   function automatic logic [63:0] prod(logic [63:0] ops);
      return 64'(ops[63:32]) * 64'(ops[31:0]);
   endfunction
   // candidate behaviours: 0 ideal, 1 inverted, 2 zero, 3 lsb flipped
   function automatic logic [63:0] ymodel(int mode, logic [63:0] ops);
      logic [63:0] p;
      p = prod(ops);
      return mode == 0 ? p : mode == 1 ? ~p : mode == 2 ? 64'd0 : p ^ 64'd1;
   endfunction
   function automatic logic [63:0] step(logic [63:0] s);
      logic [63:0] n;
      n = s >> 1;
      if (s[0]) begin
         n[63] = ~n[63];
         n[62] = ~n[62];
         n[60] = ~n[60];
         n[59] = ~n[59];
      end
      return n;
   endfunction

   assign m_ops = {m_a1, m_a0, m_b1, m_b0};
   assign f_ops = {f_a1, f_a0, f_b1, f_b0};
   assign o_ops = {o_a1, o_a0, o_b1, o_b0};
   always_comb m_y = ymodel(m_mode, m_ops);
   always_comb f_y = ymodel(0, f_ops);
   always_comb o_y = ymodel(2, o_ops);

   mul4_fitness_sequencer #(.N_VECTORS(MN), .SETTLE_CYCLES(1)) u_main (
      .clk(clk), .rst(rst), .start(m_start_sig), .seed_load(m_seed_load), .seed_in(m_seed_in),
      .a1(m_a1), .a0(m_a0), .b1(m_b1), .b0(m_b0),
      .y3(m_y[63:48]), .y2(m_y[47:32]), .y1(m_y[31:16]), .y0(m_y[15:0]),
      .busy(m_busy), .done(m_done), .score(m_score), .exact_hits(m_hits));
   mul4_fitness_sequencer #(.N_VECTORS(4), .SETTLE_CYCLES(1)) u_four (
      .clk(clk), .rst(rst), .start(f_start), .seed_load(f_seed_load), .seed_in(f_seed_in),
      .a1(f_a1), .a0(f_a0), .b1(f_b1), .b0(f_b0),
      .y3(f_y[63:48]), .y2(f_y[47:32]), .y1(f_y[31:16]), .y0(f_y[15:0]),
      .busy(f_busy), .done(f_done), .score(f_score), .exact_hits(f_hits));
   mul4_fitness_sequencer #(.N_VECTORS(1), .SETTLE_CYCLES(1)) u_one (
      .clk(clk), .rst(rst), .start(o_start), .seed_load(o_seed_load), .seed_in(o_seed_in),
      .a1(o_a1), .a0(o_a0), .b1(o_b1), .b0(o_b0),
      .y3(o_y[63:48]), .y2(o_y[47:32]), .y1(o_y[31:16]), .y0(o_y[15:0]),
      .busy(o_busy), .done(o_done), .score(o_score), .exact_hits(o_hits));

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // model of the main instance's current run
   logic [63:0] m_lfsr = SEED;
   logic [63:0] m_vecs [MN];
   int          m_exp_score = 0;
   int          m_exp_hits = 0;
   int          m_t0 = 0;
   bit          m_armed = 0;

   task automatic m_start(int mode);
      logic [63:0] s, e;
      m_armed = 0;
      m_mode = mode;
      s = m_lfsr;
      m_exp_score = 0;
      m_exp_hits = 0;
      for (int v = 0; v < MN; v++) begin
         m_vecs[v] = s;
         e = ymodel(mode, s) ^ prod(s);
         m_exp_score += 64 - $countones(e);
         m_exp_hits += (e == 64'd0) ? 1 : 0;
         s = step(s);
      end
      m_lfsr = s;
      @(negedge clk);
      m_start_sig = 1;
      @(posedge clk);
      #1 m_start_sig = 0;
      m_t0 = cyc - 1;
      m_armed = 1;
   endtask

   // vector index v is on the operands for cycles t0+2v+1 and t0+2v+2; done at t0+MLAST+1
   always @(negedge clk) begin
      int k, v;
      if (m_armed) begin
         k = cyc - m_t0;
         chk("m_busy", 64'(m_busy), 64'(k >= 1 && k <= MLAST));
         chk("m_done", 64'(m_done), 64'(k == MLAST + 1));
         v = (k > MLAST) ? MN - 1 : (k - 1) / 2;
         chk("m_ops", m_ops, m_vecs[v]);
         if (k > MLAST) begin
            chk("m_score", 64'(m_score), 64'(m_exp_score));
            chk("m_hits", 64'(m_hits), 64'(m_exp_hits));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("rst_busy", 64'(m_busy), 64'd0);
      chk("rst_done", 64'(m_done), 64'd0);
      chk("rst_score", 64'(m_score), 64'd0);
      chk("rst_hits", 64'(m_hits), 64'd0);
      chk("rst_ops", m_ops, 64'd0);
      chk("rst_f_ops", f_ops, 64'd0);
      chk("pin_step1", step(64'd1), 64'hD800_0000_0000_0000);
      chk("pin_step2", step(64'hD800_0000_0000_0000), 64'h6C00_0000_0000_0000);

      // N=4 timing, stray start at t0+3, operand stream from seed 1
      f_seed_in = 64'd1;
      f_seed_load = 1;
      @(posedge clk);
      #1 f_seed_load = 0;
      f_start = 1;
      @(posedge clk);
      #1 f_start = 0;
      for (int k = 1; k <= 11; k++) begin
         f_start = (k == 3);
         @(negedge clk);
         chk("t4_busy", 64'(f_busy), 64'(k >= 1 && k <= 8));
         chk("t4_done", 64'(f_done), 64'(k == 9));
         if (k == 1) chk("t4_ops_v0", f_ops, 64'h0000_0000_0000_0001);
         if (k == 3) chk("t4_ops_v1", f_ops, 64'hD800_0000_0000_0000);
         if (k == 5) chk("t4_ops_v2", f_ops, 64'h6C00_0000_0000_0000);
         if (k == 7) chk("t4_ops_v3", f_ops, 64'h3600_0000_0000_0000);
         if (k == 9) begin
            chk("t4_score", 64'(f_score), 64'd256);
            chk("t4_hits", 64'(f_hits), 64'd4);
         end
         @(posedge clk);
         #1;
      end
      f_start = 0;

      // N=1, seed 1, y tied to zero
      o_seed_in = 64'd1;
      o_seed_load = 1;
      @(posedge clk);
      #1 o_seed_load = 0;
      o_start = 1;
      @(posedge clk);
      #1 o_start = 0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk("t3_busy", 64'(o_busy), 64'(k <= 2));
         chk("t3_done", 64'(o_done), 64'(k == 3));
         chk("t3_ops", o_ops, 64'h0000_0000_0000_0001);
         if (k >= 3) begin
            chk("t3_score", 64'(o_score), 64'd64);
            chk("t3_hits", 64'(o_hits), 64'd1);
         end
      end

      // ideal candidate
      m_start(0);
      repeat (MLAST + 2) @(negedge clk);
      chk("t1_score", 64'(m_score), 64'd16384);
      chk("t1_hits", 64'(m_hits), 64'd256);

      // inverted candidate
      m_start(1);
      repeat (MLAST + 2) @(negedge clk);
      chk("t2_score", 64'(m_score), 64'd0);
      chk("t2_hits", 64'(m_hits), 64'd0);

      // zero candidate, with start and seed_load pulses ignored mid-run
      m_start(2);
      repeat (10) @(negedge clk);
      m_start_sig = 1;
      m_seed_load = 1;
      m_seed_in = 64'h1357_9BDF_2468_ACE0;
      @(negedge clk);
      m_start_sig = 0;
      m_seed_load = 0;
      repeat (MLAST + 2) @(negedge clk);

      // seed_load wins over start in the same cycle
      m_armed = 0;
      m_seed_in = 64'h0123_4567_89AB_CDEF;
      m_seed_load = 1;
      m_start_sig = 1;
      @(negedge clk);
      m_seed_load = 0;
      m_start_sig = 0;
      m_lfsr = 64'h0123_4567_89AB_CDEF;
      repeat (3) begin
         @(negedge clk);
         chk("prio_busy", 64'(m_busy), 64'd0);
      end

      // lsb-flipped candidate from the loaded seed
      m_start(3);
      @(negedge clk);
      chk("flip_first_ops", m_ops, 64'h0123_4567_89AB_CDEF);
      repeat (MLAST + 1) @(negedge clk);
      chk("flip_score", 64'(m_score), 64'd16128);
      chk("flip_hits", 64'(m_hits), 64'd0);

      // reset at vector 100, then a fresh ideal run
      m_start(0);
      repeat (201) @(negedge clk);
      chk("t5_vec100", m_ops, m_vecs[100]);
      m_armed = 0;
      rst = 1;
      @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("t5_busy", 64'(m_busy), 64'd0);
      chk("t5_score", 64'(m_score), 64'd0);
      chk("t5_hits", 64'(m_hits), 64'd0);
      chk("t5_ops", m_ops, 64'd0);
      repeat (4) begin
         @(negedge clk);
         chk("t5_no_done", 64'(m_done), 64'd0);
      end
      m_lfsr = SEED;
      m_start(0);
      @(negedge clk);
      chk("t5_first_ops", m_ops, 64'hACE1_1234_5EED_0001);
      repeat (MLAST + 1) @(negedge clk);
      chk("t5_rerun_score", 64'(m_score), 64'd16384);
      chk("t5_rerun_hits", 64'(m_hits), 64'd256);

      // zero seed_in restores the default seed stream
      m_armed = 0;
      @(negedge clk);
      m_seed_in = 64'd0;
      m_seed_load = 1;
      @(negedge clk);
      m_seed_load = 0;
      m_lfsr = SEED;
      m_start(0);
      @(negedge clk);
      chk("t6_first_ops", m_ops, 64'hACE1_1234_5EED_0001);
      repeat (MLAST + 1) @(negedge clk);
      chk("t6_score", 64'(m_score), 64'd16384);
      m_armed = 0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
